// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FSM states, operand classes, flag codes and canonical qNaN for the FP add unit
package fp_pkg;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} fp_state_t;

  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} fp_cls_t;

  localparam logic [1:0] FLG_OK  = 2'b00;
  localparam logic [1:0] FLG_OVF = 2'b01;
  localparam logic [1:0] FLG_UNF = 2'b10;
  localparam logic [1:0] FLG_INV = 2'b11;

  // Wide return; callers size-cast to their word width.
  function automatic logic [127:0] qnan(input int exp_w, input int man_w);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) q[man_w+i] = 1'b1;
    q[man_w-1] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fp_addsub_param_if.sv
// rtl/fp_addsub_param_if.sv - operand/result handshake bundle for fp_addsub_param
interface fp_addsub_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic [1:0]   overflow;

  modport master (
    output in_valid, op_sub, x, y, out_ready,
    input  in_ready, out_valid, z, overflow
  );

  modport slave (
    input  in_valid, op_sub, x, y, out_ready,
    output in_ready, out_valid, z, overflow
  );
endinterface

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input returns WIDTH
module fp_lzc #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    cnt
);

  // Upward scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_param.sv
// rtl/fp_addsub_param.sv - multicycle IEEE-754 add/subtract with RNE, one operation in flight
// FPADD_SUBNORM_EN: gradual underflow; undefined: subnormals flush to signed zero.
module fp_addsub_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            clk,
  input logic            rst,
  fp_addsub_param_if.slave bus
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int EXT = MAN_W + 4;
  localparam int EW  = EXP_W + 1;
  localparam int RW  = M + 1;
  localparam int SHW = $clog2(EXT + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = W'(qnan(EXP_W, MAN_W));

  fp_state_t state, state_nxt;

  logic [W-1:0]     x_r, y_r;
  logic             sub_r;
  logic             ux_s, uy_s;
  logic [EXP_W-1:0] ux_e, uy_e;
  logic [M-1:0]     ux_m, uy_m;
  logic             sp_en;
  logic [W-1:0]     sp_z;
  logic [1:0]       sp_flg;
  logic             al_s, al_sub;
  logic [EXP_W-1:0] al_e;
  logic [EXT-1:0]   al_a, al_b;
  logic             ad_s;
  logic [EXP_W-1:0] ad_e;
  logic [EXT:0]     ad_sum;
  logic             nm_s;
  logic [EW-1:0]    nm_e;
  logic [EXT-1:0]   nm_m;
  logic [W-1:0]     z_r;
  logic [1:0]       flg_r;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = UNPACK;
      UNPACK:  state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) && rst;
    bus.out_valid = (state == DONE);
  end

  assign bus.z        = z_r;
  assign bus.overflow = flg_r;

  // Subnormals get exponent 1 and no hidden bit, so they line up with the smallest normals.
  function automatic void unpack_op(input logic [W-1:0] v, output fp_cls_t cls,
                                    output logic [EXP_W-1:0] e, output logic [M-1:0] m);
    logic [EXP_W-1:0] ef;
    logic [MAN_W-1:0] ff;
    ef = v[W-2:MAN_W];
    ff = v[MAN_W-1:0];
    e  = (ef == '0) ? EXP_W'(1) : ef;
    m  = {ef != '0, ff};
    if (ef == EXP_MAX)  cls = (ff == '0) ? CLS_INF : CLS_NAN;
    else if (ef == '0)  cls = (ff == '0) ? CLS_ZERO : CLS_SUB;
    else                cls = CLS_NORM;
`ifndef FPADD_SUBNORM_EN
    if (cls == CLS_SUB) begin
      cls = CLS_ZERO;
      m   = '0;
    end
`endif
  endfunction

  fp_cls_t          cx, cy;
  logic [EXP_W-1:0] ex, ey;
  logic [M-1:0]     mx, my;
  logic             sy_eff;
  logic             sp_en_c;
  logic [W-1:0]     sp_z_c;
  logic [1:0]       sp_flg_c;

  assign sy_eff = y_r[W-1] ^ sub_r;

  always_comb begin
    unpack_op(x_r, cx, ex, mx);
    unpack_op(y_r, cy, ey, my);
  end

  always_comb begin
    sp_en_c  = 1'b0;
    sp_z_c   = '0;
    sp_flg_c = FLG_OK;
    if (cx == CLS_NAN || cy == CLS_NAN ||
        (cx == CLS_INF && cy == CLS_INF && x_r[W-1] != sy_eff)) begin
      sp_en_c  = 1'b1;
      sp_z_c   = QNAN;
      sp_flg_c = FLG_INV;
    end else if (cx == CLS_INF) begin
      sp_en_c = 1'b1;
      sp_z_c  = x_r;
    end else if (cy == CLS_INF) begin
      sp_en_c = 1'b1;
      sp_z_c  = {sy_eff, y_r[W-2:0]};
    end
  end

  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e, e_diff;
  logic [M-1:0]     a_m, b_m;
  logic [SHW-1:0]   shamt;
  logic [EXT-1:0]   b_al, b_ext;

  // B keeps its shifted-out bits as a sticky LSB so a subtraction borrows correctly.
  always_comb begin
    if ({ux_e, ux_m} >= {uy_e, uy_m}) begin
      a_s = ux_s; a_e = ux_e; a_m = ux_m;
      b_s = uy_s; b_e = uy_e; b_m = uy_m;
    end else begin
      a_s = uy_s; a_e = uy_e; a_m = uy_m;
      b_s = ux_s; b_e = ux_e; b_m = ux_m;
    end
    e_diff = a_e - b_e;
    shamt  = (int'(e_diff) >= EXT) ? SHW'(EXT) : SHW'(e_diff);
    b_al   = {b_m, 3'b000};
    b_ext  = (b_al >> shamt) | {{(EXT-1){1'b0}}, |(b_al & ~({EXT{1'b1}} << shamt))};
  end

  logic [EXT:0] sum_c;
  logic         sum_s_c;

  always_comb begin
    if (al_sub) sum_c = {1'b0, al_a} - {1'b0, al_b};
    else        sum_c = {1'b0, al_a} + {1'b0, al_b};
    sum_s_c = al_s & ~(al_sub && sum_c == '0);
  end

  logic [SHW-1:0] lz;
  logic [EXT-1:0] nm_m_c;
  logic [EW-1:0]  nm_e_c;

  fp_lzc #(.WIDTH(EXT)) u_lzc (
    .din (ad_sum[EXT-1:0]),
    .cnt (lz)
  );

  // Left shift stops at exponent 1 so tiny results stay subnormal instead of wrapping.
  always_comb begin : norm_c
    int sh;
    int room;
    room   = int'(ad_e) - 1;
    sh     = 0;
    nm_m_c = ad_sum[EXT-1:0];
    nm_e_c = {1'b0, ad_e};
    if (ad_sum[EXT]) begin
      nm_m_c = {ad_sum[EXT:2], ad_sum[1] | ad_sum[0]};
      nm_e_c = {1'b0, ad_e} + EW'(1);
    end else begin
      sh     = (int'(lz) < room) ? int'(lz) : room;
      nm_m_c = ad_sum[EXT-1:0] << sh;
      nm_e_c = {1'b0, ad_e} - EW'(sh);
    end
  end

  logic [RW-1:0] rm;
  logic [EW-1:0] re;
  logic          inexact;
  logic [W-1:0]  z_c;
  logic [1:0]    flg_c;

  always_comb begin
    inexact = |nm_m[2:0];
    rm      = {1'b0, nm_m[EXT-1:3]} + RW'(nm_m[2] & (nm_m[1] | nm_m[0] | nm_m[3]));
    re      = nm_e;
    if (rm[M]) begin
      rm = rm >> 1;
      re = re + EW'(1);
    end
    z_c   = {nm_s, re[EXP_W-1:0], rm[MAN_W-1:0]};
    flg_c = FLG_OK;
    if (sp_en) begin
      z_c   = sp_z;
      flg_c = sp_flg;
    end else if (re >= {1'b0, EXP_MAX}) begin
      z_c   = {nm_s, EXP_MAX, {MAN_W{1'b0}}};
      flg_c = FLG_OVF;
    end else if (!rm[M-1]) begin
      z_c = {nm_s, {EXP_W{1'b0}}, rm[MAN_W-1:0]};
      if (rm != '0 || inexact) begin
        flg_c = FLG_UNF;
`ifndef FPADD_SUBNORM_EN
        z_c = {nm_s, {(W-1){1'b0}}};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      z_r   <= '0;
      flg_r <= FLG_OK;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x_r   <= bus.x;
          y_r   <= bus.y;
          sub_r <= bus.op_sub;
        end
        UNPACK: begin
          ux_s   <= x_r[W-1];
          ux_e   <= ex;
          ux_m   <= mx;
          uy_s   <= sy_eff;
          uy_e   <= ey;
          uy_m   <= my;
          sp_en  <= sp_en_c;
          sp_z   <= sp_z_c;
          sp_flg <= sp_flg_c;
        end
        ALIGN: begin
          al_s   <= a_s;
          al_sub <= a_s ^ b_s;
          al_e   <= a_e;
          al_a   <= {a_m, 3'b000};
          al_b   <= b_ext;
        end
        ADD: begin
          ad_s   <= sum_s_c;
          ad_e   <= al_e;
          ad_sum <= sum_c;
        end
        NORM: begin
          nm_s <= ad_s;
          nm_e <= nm_e_c;
          nm_m <= nm_m_c;
        end
        ROUND: begin
          z_r   <= z_c;
          flg_r <= flg_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_param.sv
// tb/tb_fp_addsub_param.sv - directed vectors for fp_addsub_param (binary32)
module tb_fp_addsub_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_param_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.x        = a;
    bus.y        = b;
    bus.op_sub   = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] ez, input logic [1:0] ef);
    int lat;
    issue(a, b, s);
    wait_result(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_z"}, 64'(bus.z), 64'(ez));
    chk({tag, "_flg"}, 64'(bus.overflow), 64'(ef));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    logic seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_sub    = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_z", 64'(bus.z), 64'd0);
    chk("rst_flg", 64'(bus.overflow), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    run_vec("one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 2'b00);
    run_vec("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00);
    run_vec("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00);
    run_vec("tie_up",        32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 2'b00);
    run_vec("ovf",           32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01);
    run_vec("inf_m_inf",     32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b11);
    run_vec("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11);
    run_vec("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2'b00);
    run_vec("one_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2'b00);
    run_vec("negz_negz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2'b00);
    run_vec("x_plus_zero",   32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 2'b00);
    run_vec("one_m_two",     32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 2'b00);
    run_vec("one_m_ulp",     32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 2'b00);
    run_vec("mixed_signs",   32'h3FC00000, 32'hBF000000, 1'b0, 32'h3F800000, 2'b00);
`ifdef FPADD_SUBNORM_EN
    run_vec("sub_result",    32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 2'b10);
`else
    run_vec("sub_flush",     32'h00800000, 32'h00000001, 1'b1, 32'h00800000, 2'b00);
`endif

    issue(32'h3F800000, 32'h40000000, 1'b0);
    wait_result(lat);
    chk("stall_lat", 64'(lat), 64'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_z", 64'(bus.z), 64'h40400000);
      chk("stall_flg", 64'(bus.overflow), 64'd0);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    issue(32'h3F800000, 32'h40000000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | bus.out_valid;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    chk("midrst_idle", 64'(bus.in_ready), 64'd1);
    run_vec("after_rst", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
